// File: rtl/mc_hit_counter_pkg.sv
// mc_pkg: definitions shared by the Monte Carlo quarter-circle hit counter and
// by later Monte Carlo stages.
//   state_t       - controller states (SQUARE exists only in the registered-square build)
//   COORD_W_DEF   - default coordinate width
//   SAMPLES_W_DEF - default width of the sample / hit counters
//   RND_W         - width of the random generator output word
package mc_pkg;

   localparam int COORD_W_DEF   = 16;
   localparam int SAMPLES_W_DEF = 16;
   localparam int RND_W         = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_X,
      ST_GET_Y,
      ST_SQUARE,
      ST_EVAL,
      ST_DONE
   } state_t;

endpackage : mc_pkg

// File: rtl/mc_hit_counter_if.sv
// mc_hit_counter_if: control, random-word and result signals of the hit counter.
//   start_i, nsamples_i     - run request and sample count
//   rnd_i, rnd_valid_i      - random word stream from the generator
//   busy_o, done_o          - run status and end-of-run pulse
//   hits_o, samples_o       - hit count and samples evaluated so far
// Modports: master (requester / generator side), slave (the counter).
interface mc_hit_counter_if
   import mc_pkg::*;
#(
   parameter int SAMPLES_W = SAMPLES_W_DEF
);

   logic                 start_i;
   logic [SAMPLES_W-1:0] nsamples_i;
   logic [RND_W-1:0]     rnd_i;
   logic                 rnd_valid_i;
   logic                 busy_o;
   logic                 done_o;
   logic [SAMPLES_W-1:0] hits_o;
   logic [SAMPLES_W-1:0] samples_o;

   modport master (
      output start_i, nsamples_i, rnd_i, rnd_valid_i,
      input  busy_o, done_o, hits_o, samples_o
   );

   modport slave (
      input  start_i, nsamples_i, rnd_i, rnd_valid_i,
      output busy_o, done_o, hits_o, samples_o
   );

endinterface : mc_hit_counter_if

// File: rtl/mc_hit_counter_quarter_circle.sv
// mc_quarter_circle: combinational test of a point (x, y) in the unit square
// against the quarter circle x^2 + y^2 < 1.
//   x, y - unsigned fixed-point coordinates, COORD_W fractional bits
//   sum  - x^2 + y^2 at full precision (2*COORD_W+1 bits)
//   hit  - 1 when sum < 2^(2*COORD_W), i.e. the point lies inside the circle
module mc_quarter_circle
   import mc_pkg::*;
#(
   parameter int COORD_W = COORD_W_DEF
) (
   input  logic [COORD_W-1:0]   x,
   input  logic [COORD_W-1:0]   y,
   output logic [2*COORD_W:0]   sum,
   output logic                 hit
);

   logic [2*COORD_W-1:0] x_wide;
   logic [2*COORD_W-1:0] y_wide;
   logic [2*COORD_W-1:0] x_sq;
   logic [2*COORD_W-1:0] y_sq;

   // Widen before multiplying so the full product is kept.
   assign x_wide = {{COORD_W{1'b0}}, x};
   assign y_wide = {{COORD_W{1'b0}}, y};
   assign x_sq   = x_wide * x_wide;
   assign y_sq   = y_wide * y_wide;
   assign sum    = {1'b0, x_sq} + {1'b0, y_sq};
   assign hit    = ~sum[2*COORD_W];

endmodule : mc_quarter_circle

// File: rtl/mc_hit_counter.sv
// mc_hit_counter: Monte Carlo pi evaluator. Consumes random words in (x, y)
// pairs, counts points inside the quarter circle over nsamples_i samples and
// pulses done_o at the end of the run (pi ~= 4*hits/samples).
//   clk - clock
//   rst - asynchronous, active-low reset
//   bus - mc_hit_counter_if.slave (start/nsamples, rnd stream, busy/done/hits/samples)
// Build option MC_HIT_SQUARE_REG_EN: inserts a SQUARE state that registers x^2
// and y^2 before EVAL (4 cycles per sample instead of 3). Results are identical.
module mc_hit_counter
   import mc_pkg::*;
#(
   parameter int SAMPLES_W = SAMPLES_W_DEF,
   parameter int COORD_W   = COORD_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   mc_hit_counter_if.slave bus
);

   localparam int                   SUM_W = 2*COORD_W + 1;
   localparam logic [SAMPLES_W-1:0] ONE   = SAMPLES_W'(1);

   state_t               state_reg, state_next;
   logic [COORD_W-1:0]   x_reg, x_next;
   logic [COORD_W-1:0]   y_reg, y_next;
   logic [SAMPLES_W-1:0] remaining_reg, remaining_next;
   logic [SAMPLES_W-1:0] hits_reg, hits_next;
   logic [SAMPLES_W-1:0] samples_reg, samples_next;
   logic [COORD_W-1:0]   coord;
   logic                 eval_hit;

   // Coordinates are the most significant bits of the random word.
   assign coord = bus.rnd_i[RND_W-1 -: COORD_W];

   if (COORD_W < RND_W) begin : g_rnd_low
      logic rnd_low_unused;
      assign rnd_low_unused = ^bus.rnd_i[RND_W-COORD_W-1:0];
   end

`ifdef MC_HIT_SQUARE_REG_EN
   logic [2*COORD_W-1:0] x_sq_reg, x_sq_next;
   logic [2*COORD_W-1:0] y_sq_reg, y_sq_next;
   logic [2*COORD_W-1:0] x_wide, y_wide;
   logic [SUM_W-1:0]     sq_sum;

   assign x_wide   = {{COORD_W{1'b0}}, x_reg};
   assign y_wide   = {{COORD_W{1'b0}}, y_reg};
   assign sq_sum   = {1'b0, x_sq_reg} + {1'b0, y_sq_reg};
   assign eval_hit = ~sq_sum[SUM_W-1];
`else
   logic [SUM_W-1:0] qc_sum;
   logic             qc_hit;
   logic             qc_sum_unused;

   mc_quarter_circle #(.COORD_W(COORD_W)) u_quarter_circle (
      .x   (x_reg),
      .y   (y_reg),
      .sum (qc_sum),
      .hit (qc_hit)
   );

   assign eval_hit = qc_hit;
   // The full sum is exported for other stages; only the hit flag is counted here.
   assign qc_sum_unused = ^qc_sum;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= ST_IDLE;
         x_reg         <= '0;
         y_reg         <= '0;
         remaining_reg <= '0;
         hits_reg      <= '0;
         samples_reg   <= '0;
`ifdef MC_HIT_SQUARE_REG_EN
         x_sq_reg      <= '0;
         y_sq_reg      <= '0;
`endif
      end else begin
         state_reg     <= state_next;
         x_reg         <= x_next;
         y_reg         <= y_next;
         remaining_reg <= remaining_next;
         hits_reg      <= hits_next;
         samples_reg   <= samples_next;
`ifdef MC_HIT_SQUARE_REG_EN
         x_sq_reg      <= x_sq_next;
         y_sq_reg      <= y_sq_next;
`endif
      end
   end

   always_comb begin
      state_next     = state_reg;
      x_next         = x_reg;
      y_next         = y_reg;
      remaining_next = remaining_reg;
      hits_next      = hits_reg;
      samples_next   = samples_reg;
`ifdef MC_HIT_SQUARE_REG_EN
      x_sq_next      = x_sq_reg;
      y_sq_next      = y_sq_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            if (bus.start_i) begin
               hits_next    = '0;
               samples_next = '0;
               if (bus.nsamples_i != '0) begin
                  remaining_next = bus.nsamples_i;
                  state_next     = ST_GET_X;
               end else begin
                  state_next     = ST_DONE;
               end
            end
         end
         ST_GET_X: begin
            if (bus.rnd_valid_i) begin
               x_next     = coord;
               state_next = ST_GET_Y;
            end
         end
         ST_GET_Y: begin
            if (bus.rnd_valid_i) begin
               y_next = coord;
`ifdef MC_HIT_SQUARE_REG_EN
               state_next = ST_SQUARE;
`else
               state_next = ST_EVAL;
`endif
            end
         end
`ifdef MC_HIT_SQUARE_REG_EN
         ST_SQUARE: begin
            x_sq_next  = x_wide * x_wide;
            y_sq_next  = y_wide * y_wide;
            state_next = ST_EVAL;
         end
`endif
         ST_EVAL: begin
            hits_next      = hits_reg + {{(SAMPLES_W-1){1'b0}}, eval_hit};
            samples_next   = samples_reg + ONE;
            remaining_next = remaining_reg - ONE;
            state_next     = (remaining_reg == ONE) ? ST_DONE : ST_GET_X;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign bus.busy_o    = (state_reg != ST_IDLE);
   assign bus.done_o    = (state_reg == ST_DONE);
   assign bus.hits_o    = hits_reg;
   assign bus.samples_o = samples_reg;

endmodule : mc_hit_counter

// File: tb/tb_mc_hit_counter.sv
// tb_mc_hit_counter: scoreboard bench for mc_hit_counter. Stimulus pushes the
// expected hits, samples and done cycle of each run; a monitor pops and
// compares whenever done_o is seen. Prints one line per completed run.
module tb_mc_hit_counter;
   import mc_pkg::*;

   localparam int SW = 16;
`ifdef MC_HIT_SQUARE_REG_EN
   localparam int SPS = 4;
`else
   localparam int SPS = 3;
`endif

   typedef struct {
      int unsigned hits;
      int unsigned samples;
      int unsigned cyc;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mc_hit_counter_if #(.SAMPLES_W(SW)) bus ();

   mc_hit_counter #(.SAMPLES_W(SW), .COORD_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] wx[0:1023];
   logic [31:0] wy[0:1023];

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Monitor: compare each done pulse against the oldest expected run.
   always @(negedge clk) begin
      exp_t e;
      if (rst && bus.done_o) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got done_o=1 at cycle %0d, expected no pulse", cyc);
         end else begin
            e = sb_q.pop_front();
            chk({e.name, "_hits"}, bus.hits_o, e.hits);
            chk({e.name, "_samples"}, bus.samples_o, e.samples);
            chk({e.name, "_done_cycle"}, cyc, e.cyc);
            $display("run %s: hits=%0d samples=%0d done at cycle %0d", e.name, bus.hits_o, bus.samples_o, cyc);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got simulation timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] xorshift(input logic [31:0] s);
      logic [31:0] v;
      v = s;
      v = v ^ (v << 13);
      v = v ^ (v >> 17);
      v = v ^ (v << 5);
      return v;
   endfunction

   task automatic wait_sb(input string name);
      for (int i = 0; i < 50 && sb_q.size() > 0; i++) @(negedge clk);
      if (sb_q.size() > 0) begin
         n_checks++;
         $display("FAIL %s_timeout: got %0d pending results, expected 0", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   // Called at a negedge; the start is accepted at the next posedge (E0).
   task automatic issue(input string name, input int n, input int exp_hits, input int extra, input bit push);
      exp_t e;
      bus.start_i    = 1'b1;
      bus.nsamples_i = n[SW-1:0];
      if (push) begin
         e.hits    = exp_hits;
         e.samples = n;
         e.cyc     = cyc + 1 + SPS*n + extra;
         e.name    = name;
         sb_q.push_back(e);
      end
   endtask

   // Full-rate run using wx/wy; junk words in the other slots must be ignored.
   task automatic run_pts(input string name, input int n, input int exp_hits, input bit inject);
      issue(name, n, exp_hits, 0, 1'b1);
      for (int j = 1; j <= SPS*n; j++) begin
         @(negedge clk);
         bus.start_i     = 1'b0;
         bus.rnd_valid_i = 1'b1;
         if (inject && (j % 97 == 0)) begin
            bus.start_i    = 1'b1;
            bus.nsamples_i = 16'd3;
         end
         if (j % SPS == 1)      bus.rnd_i = wx[(j-1)/SPS];
         else if (j % SPS == 2) bus.rnd_i = wy[(j-1)/SPS];
         else                   bus.rnd_i = 32'hFFFF_FFFF;
      end
      @(negedge clk);                // DONE cycle: a start here must be ignored
      bus.start_i    = inject;
      bus.nsamples_i = 16'd3;
      @(negedge clk);
      bus.start_i = 1'b0;
      chk({name, "_idle_after"}, bus.busy_o, 0);
      wait_sb(name);
   endtask

   initial begin
      logic [31:0]     seed;
      logic [15:0]     xc, yc;
      longint unsigned s;
      int              model_hits;
      int              pi_ok;

      bus.start_i     = 1'b0;
      bus.nsamples_i  = '0;
      bus.rnd_i       = '0;
      bus.rnd_valid_i = 1'b0;

      repeat (3) @(negedge clk);
      chk("reset_busy", bus.busy_o, 0);
      chk("reset_done", bus.done_o, 0);
      chk("reset_hits", bus.hits_o, 0);
      chk("reset_samples", bus.samples_o, 0);
      rst = 1'b1;
      @(negedge clk);

      // Hit and miss corners
      wx[0] = 32'h0000_0000; wy[0] = 32'h0000_0000;
      wx[1] = 32'hFFFF_0000; wy[1] = 32'hFFFF_0000;
      run_pts("corners", 2, 1, 1'b0);

      // Circle boundary
      wx[0] = 32'hB504_0000; wy[0] = 32'hB504_0000;
      wx[1] = 32'hB505_0000; wy[1] = 32'hB505_0000;
      run_pts("boundary", 2, 1, 1'b0);
      run_pts("boundary_hit", 1, 1, 1'b0);
      wx[0] = 32'hB505_0000; wy[0] = 32'hB505_0000;
      run_pts("boundary_miss", 1, 0, 1'b0);

      // Valid gaps: 3 idle cycles in GET_X, 2 in GET_Y
      issue("gaps", 1, 1, 5, 1'b1);
      @(negedge clk); bus.start_i = 1'b0; bus.rnd_valid_i = 1'b0; bus.rnd_i = 32'hFFFF_0000;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); bus.rnd_valid_i = 1'b1; bus.rnd_i = 32'h8000_0000;
      @(negedge clk); bus.rnd_valid_i = 1'b0; bus.rnd_i = 32'hFFFF_0000;
      @(negedge clk);
      @(negedge clk); bus.rnd_valid_i = 1'b1; bus.rnd_i = 32'h8000_0000;
      for (int j = 0; j < SPS-2; j++) begin
         @(negedge clk); bus.rnd_i = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      @(negedge clk);
      chk("gaps_idle_after", bus.busy_o, 0);
      wait_sb("gaps");

      // Zero samples
      issue("zero", 0, 0, 0, 1'b1);
      @(negedge clk); bus.start_i = 1'b0;
      chk("zero_busy_first", bus.busy_o, 1);
      @(negedge clk);
      chk("zero_busy_second", bus.busy_o, 0);
      wait_sb("zero");

      // Reset during EVAL of sample 3 of 10
      bus.rnd_i = 32'h0000_0000; bus.rnd_valid_i = 1'b1;
      issue("reset_run", 10, 0, 0, 1'b0);
      repeat (SPS*3) begin
         @(negedge clk); bus.start_i = 1'b0;
      end
      chk("midrun_busy", bus.busy_o, 1);
      chk("midrun_samples", bus.samples_o, 2);
      chk("midrun_hits", bus.hits_o, 2);
      rst = 1'b0;
      #1;
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_done", bus.done_o, 0);
      chk("rst_hits", bus.hits_o, 0);
      chk("rst_samples", bus.samples_o, 0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("rst_stays_idle", bus.busy_o, 0);
      wx[0] = 32'h0000_0000; wy[0] = 32'h0000_0000;
      run_pts("after_reset", 1, 1, 1'b0);

      // Long run: xorshift32 generator, reference model counts hits
      seed = 32'h1234_5678;
      model_hits = 0;
      for (int i = 0; i < 1000; i++) begin
         seed = xorshift(seed); wx[i] = seed;
         seed = xorshift(seed); wy[i] = seed;
         xc = wx[i][31:16];
         yc = wy[i][31:16];
         s  = longint'(xc) * longint'(xc) + longint'(yc) * longint'(yc);
         if (s < 64'h1_0000_0000) model_hits++;
      end
      run_pts("long", 1000, model_hits, 1'b1);
      pi_ok = ((4 * int'(bus.hits_o) >= 2900) && (4 * int'(bus.hits_o) <= 3400)) ? 1 : 0;
      chk("long_pi_range", pi_ok, 1);
      $display("long run pi estimate: 4*%0d/1000", bus.hits_o);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_mc_hit_counter

// File: doc/mc_hit_counter.md
# mc_hit_counter

Monte Carlo sample evaluator sitting directly downstream of the 32-bit random number generator. It consumes the generator's output words in pairs as (x, y) coordinates in the unit square and tests each point against the quarter circle x² + y² < 1. It counts hits over a programmed number of samples and reports the hit count with a done pulse, giving the pi estimate 4·hits/samples.

## Interface
Parameters:
- SAMPLES_W, default 16: width of the sample-count and hit-count registers.
- COORD_W, default 16: coordinate width; the top COORD_W bits of each random word are used.

Ports:
- clk, input, 1: sole clock.
- rst, input, 1: reset. Asynchronous assert, active-low (0 = reset).
- start_i, input, 1: begin a run. Sampled in IDLE only.
- nsamples_i, input, SAMPLES_W: number of (x, y) samples for the run. Latched on start.
- rnd_i, input, 32: random word from the generator.
- rnd_valid_i, input, 1: rnd_i is fresh this cycle. Tie to 1 when the generator runs every clock.
- busy_o, output, 1: a run is in progress.
- done_o, output, 1: one-cycle pulse at the end of a run.
- hits_o, output, SAMPLES_W: hit count. Held stable from done_o until the next accepted start.
- samples_o, output, SAMPLES_W: samples evaluated so far in the current run.

## Operation
- States: IDLE, GET_X, GET_Y, EVAL, DONE.
- IDLE:
  - start_i=1 and nsamples_i≠0: latch the remaining count, clear hits_o and samples_o, go to GET_X.
  - start_i=1 and nsamples_i=0: clear hits_o and samples_o, go to DONE.
- GET_X: on rnd_valid_i, x ← rnd_i[31:32-COORD_W], go to GET_Y. Otherwise stay.
- GET_Y: on rnd_valid_i, y ← rnd_i[31:32-COORD_W], go to EVAL. Otherwise stay.
- EVAL:
  - sum = x² + y², computed at 2·COORD_W+1 bits. hit = (sum[2·COORD_W] == 0), i.e. sum < 2^(2·COORD_W).
  - hits += hit; samples += 1; remaining −= 1.
  - remaining reaches 0 → DONE, else → GET_X.
  - rnd_i is ignored in this state.
- DONE: done_o=1 for exactly one cycle, then → IDLE.
- start_i is ignored outside IDLE, including in DONE.
- No overflow is possible: hits ≤ samples ≤ nsamples_i < 2^SAMPLES_W.
- Reset mid-run: state → IDLE, all registers cleared. The partial run is discarded.

## Timing
- Reset values: busy_o=0, done_o=0, hits_o=0, samples_o=0. State=IDLE; x, y and remaining = 0.
- busy_o = 1 in GET_X, GET_Y, EVAL and DONE.
- With rnd_valid_i held at 1 and start accepted at edge E0:
  - Sample k uses the words at edges E(3k−2) and E(3k−1) and is accumulated at E(3k).
  - done_o is high in the cycle after E(3N).
  - IDLE is re-entered at E(3N+1).
- Each cycle that rnd_valid_i=0 in GET_X or GET_Y adds one cycle of latency.
- nsamples_i=0: done_o is high in the cycle after E0, with hits_o=0.
- hits_o and samples_o update at the EVAL edge and are visible the next cycle.

## Configuration
- MC_HIT_SQUARE_REG_EN defined:
  - An extra state SQUARE is inserted between GET_Y and EVAL, registering x² and y².
  - EVAL adds the registered squares.
  - A sample costs 4 cycles; done_o follows E(4N).
- Not defined: squares and sum are combinational within EVAL; a sample costs 3 cycles.
- Hit results are identical in both builds.

## Structure
- Shared package mc_pkg holds:
  - the state enumeration, including SQUARE;
  - COORD_W_DEF = 16 and SAMPLES_W_DEF = 16;
  - RND_W = 32.
- Sub-module mc_quarter_circle: combinational. Inputs x and y; outputs sum and hit.
  - Reused by later Monte Carlo stages.
  - The SQUARE register lives in the parent.

## Test plan
- Hit and miss corners: start, nsamples=2; rnd words 0x00000000, 0x00000000, 0xFFFF0000, 0xFFFF0000 → hits_o=1, samples_o=2, done_o at E6.
- Circle boundary: x=y=0xB504 gives sum 4294791200 → hit. x=y=0xB505 gives sum 4294976562 → miss. nsamples=2 → hits_o=1.
- Valid gaps: nsamples=1, rnd_valid_i low for 3 cycles in GET_X and 2 in GET_Y → done_o at E8, result unchanged.
- Zero samples: start with nsamples=0 → done_o in the cycle after E0, hits_o=0, busy_o high for 1 cycle.
- Reset mid-run: rst low during EVAL of sample 3 of 10 → all outputs 0 immediately, state IDLE; a new start then runs normally.
- Long run with the generator connected: nsamples=1000, seed 0x12345678 → hits_o matches the bench reference model, and 4·hits/1000 lies in [2.9, 3.4]. Start pulses during busy_o are ignored.
